// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter sharing the register-file write port between ALU and load streams, plus busy scoreboard.
// Optional macro REGWB_ZERO_GUARD_EN hardwires register 0 as zero (no write strobe, never busy).
module regfile_wb_arbiter #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    input  logic [4:0]    alu_reg,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [4:0]    mem_reg,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    input  logic          issue_valid,
    input  logic [4:0]    issue_reg,
    input  logic [4:0]    Read_register1,
    input  logic [4:0]    Read_register2,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          RegWrite,
    output logic [4:0]    Write_register,
    output logic [DW-1:0] Write_data
);

    localparam logic LG_ALU = 1'b0;
    localparam logic LG_MEM = 1'b1;

    logic            last_grant_q, last_grant_d;
    logic            regwrite_q, regwrite_d;
    logic [4:0]      write_register_q, write_register_d;
    logic [DW-1:0]   write_data_q, write_data_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic            grant_alu, grant_mem, xfer, wr_en, set_en;
    logic [4:0]      win_reg;
    logic [DW-1:0]   win_data;

    // Tie goes to whichever requester did not win the previous transfer.
    always_comb begin
        grant_alu = !reset && alu_valid && (!mem_valid || (last_grant_q == LG_MEM));
        grant_mem = !reset && mem_valid && (!alu_valid || (last_grant_q == LG_ALU));
        xfer      = grant_alu || grant_mem;
        win_reg   = grant_alu ? alu_reg  : mem_reg;
        win_data  = grant_alu ? alu_data : mem_data;
`ifdef REGWB_ZERO_GUARD_EN
        wr_en     = xfer && (win_reg != 5'd0);
        set_en    = issue_valid && (issue_reg != 5'd0);
`else
        wr_en     = xfer;
        set_en    = issue_valid;
`endif
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;

    always_comb begin
        last_grant_d     = last_grant_q;
        regwrite_d       = wr_en;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        busy_d           = busy_q;
        if (xfer) begin
            last_grant_d     = grant_alu ? LG_ALU : LG_MEM;
            busy_d[win_reg]  = 1'b0;
        end
        if (wr_en) begin
            write_register_d = win_reg;
            write_data_d     = win_data;
        end
        // Applied after the clear so a new producer on the same index stays outstanding.
        if (set_en) begin
            busy_d[issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q     <= LG_MEM;
            regwrite_q       <= 1'b0;
            write_register_q <= 5'd0;
            write_data_q     <= '0;
            busy_q           <= '0;
        end else begin
            last_grant_q     <= last_grant_d;
            regwrite_q       <= regwrite_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
            busy_q           <= busy_d;
        end
    end

    assign RegWrite       = regwrite_q;
    assign Write_register = write_register_q;
    assign Write_data     = write_data_q;

`ifdef REGWB_ZERO_GUARD_EN
    assign rs1_busy = busy_q[Read_register1] && (Read_register1 != 5'd0);
    assign rs2_busy = busy_q[Read_register2] && (Read_register2 != 5'd0);
`else
    assign rs1_busy = busy_q[Read_register1];
    assign rs2_busy = busy_q[Read_register2];
`endif

endmodule
